i2c_read_scheduler: RTL and testbench

Shares the single-register I2C read engine between N client requesters with round-robin fairness. Each client asks for one 8-bit register and gets back the data byte or an error. The block sits between the client logic and the I2C engine. It owns the engine's address/start inputs and watches its data/done outputs. A watchdog recovers from transactions in which the engine never reports done, for example a missing ACK from the worker.

---
 rtl/i2c_sched_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/i2c_read_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_i2c_read_scheduler.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_sched_pkg.sv
// rtl/i2c_sched_pkg.sv - shared types and constants for the I2C read scheduler
package i2c_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  localparam logic [6:0] WORKER_ADDR = 7'h68;
  localparam int         TMO_W       = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first requester at or after ptr
module rr_arbiter #(
  parameter int W  = 3,
  parameter int PW = 2
) (
  input  logic [W-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [W-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any
);

  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;
  logic          hi_found;

  // Descending scan leaves the lowest match in each candidate; the upper half wins over wrap-around.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i] && (PW'(i) >= ptr)) begin
        hi_idx   = PW'(i);
        hi_found = 1'b1;
      end
      if (req[i]) begin
        lo_idx = PW'(i);
      end
    end
  end

  assign any       = |req;
  assign grant_idx = hi_found ? hi_idx : lo_idx;

  always_comb begin
    grant = '0;
    for (int i = 0; i < W; i++) begin
      grant[i] = any && (PW'(i) == grant_idx);
    end
  end

endmodule

// File: rtl/i2c_read_scheduler.sv
// rtl/i2c_read_scheduler.sv - round-robin sharing of one I2C register-read engine between N clients
// Optional auto-poll requester (extra arbiter slot N) enabled by I2C_SCHED_POLL_EN.
module i2c_read_scheduler #(
  parameter int          N       = 3,
  parameter logic [15:0] TIMEOUT = 16'd2000
`ifdef I2C_SCHED_POLL_EN
  ,
  parameter logic [7:0]  POLL_BASE   = 8'h3B,
  parameter logic [3:0]  POLL_LEN    = 4'd6,
  parameter logic [19:0] POLL_PERIOD = 20'd100000
`endif
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_addr,
  output logic [N-1:0]   rsp_valid,
  output logic [7:0]     rsp_data,
  output logic           rsp_err,
  output logic           busy,
  output logic [7:0]     i2c_addr,
  output logic           i2c_start,
  input  logic [7:0]     i2c_data,
  input  logic           i2c_done,
  output logic           poll_valid,
  output logic [7:0]     poll_addr,
  output logic [7:0]     poll_data
);

  import i2c_sched_pkg::*;

`ifdef I2C_SCHED_POLL_EN
  localparam int W = N + 1;
`else
  localparam int W = N;
`endif
  localparam int PW = (W > 1) ? $clog2(W) : 1;

  sched_state_t     state, state_next;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    grant_idx;
  logic [W-1:0]     grant_oh;
  logic [W-1:0]     arb_req;
  logic [W-1:0]     arb_grant;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;
  logic [7:0]       arb_addr;
  logic [TMO_W-1:0] cnt;
  logic [TMO_W-1:0] cnt_inc;
  logic [7:0]       data_q;
  logic             err_q;
  logic             expired;

  rr_arbiter #(
    .W  (W),
    .PW (PW)
  ) u_arb (
    .req       (arb_req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  assign cnt_inc = cnt + 16'd1;
  assign expired = (cnt_inc == TIMEOUT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (arb_any) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (i2c_done || expired) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef I2C_SCHED_POLL_EN
  logic [19:0] poll_timer;
  logic        poll_active;
  logic [3:0]  poll_idx;
  logic        poll_tick;

  assign poll_tick = (poll_timer == POLL_PERIOD - 20'd1);
  assign arb_req   = {poll_active, req};

  // A tick arriving while a burst is still pending is dropped; the timer never stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      poll_timer  <= 20'd0;
      poll_active <= 1'b0;
      poll_idx    <= 4'd0;
    end else begin
      poll_timer <= poll_tick ? 20'd0 : poll_timer + 20'd1;
      if ((state == RESP) && grant_oh[N]) begin
        poll_idx <= poll_idx + 4'd1;
        if (poll_idx == POLL_LEN - 4'd1) begin
          poll_active <= 1'b0;
          poll_idx    <= 4'd0;
        end
      end else if (poll_tick && !poll_active) begin
        poll_active <= 1'b1;
        poll_idx    <= 4'd0;
      end
    end
  end

  always_comb begin
    arb_addr = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (arb_grant[i]) arb_addr = req_addr[8*i +: 8];
    end
    if (arb_grant[N]) arb_addr = POLL_BASE + {4'd0, poll_idx};
  end

  assign poll_valid = (state == RESP) && grant_oh[N] && !err_q;
  assign poll_addr  = poll_valid ? i2c_addr : 8'h00;
  assign poll_data  = poll_valid ? data_q : 8'h00;
`else
  assign arb_req = req;

  always_comb begin
    arb_addr = 8'h00;
    for (int i = 0; i < N; i++) begin
      if (arb_grant[i]) arb_addr = req_addr[8*i +: 8];
    end
  end

  assign poll_valid = 1'b0;
  assign poll_addr  = 8'h00;
  assign poll_data  = 8'h00;
`endif

  // Grant and address are frozen at the IDLE decision so a dropped req cannot disturb the transfer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      grant_idx <= '0;
      grant_oh  <= '0;
      i2c_addr  <= 8'h00;
      cnt       <= '0;
      data_q    <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_idx <= arb_idx;
            grant_oh  <= arb_grant;
            i2c_addr  <= arb_addr;
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt_inc;
          if (i2c_done) begin
            data_q <= i2c_data;
            err_q  <= 1'b0;
          end else if (expired) begin
            data_q <= 8'h00;
            err_q  <= 1'b1;
          end
        end
        RESP: ptr <= (grant_idx == PW'(W - 1)) ? '0 : grant_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign i2c_start = (state == ISSUE);
  assign rsp_valid = (state == RESP) ? grant_oh[N-1:0] : '0;
  assign rsp_data  = (state == RESP) ? data_q : 8'h00;
  assign rsp_err   = (state == RESP) && err_q;

endmodule

// File: tb/tb_i2c_read_scheduler.sv
// tb/tb_i2c_read_scheduler.sv - scoreboard bench for i2c_read_scheduler (engine model returns addr ^ 8'h1D)
module tb_i2c_read_scheduler;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [2:0]  req_a;
  logic [23:0] req_addr_a;
  logic [2:0]  rsp_valid_a;
  logic [7:0]  rsp_data_a, i2c_addr_a, i2c_data_a, poll_addr_a, poll_data_a;
  logic        rsp_err_a, busy_a, i2c_start_a, i2c_done_a, poll_valid_a;

  logic        req_b;
  logic [7:0]  req_addr_b;
  logic        rsp_valid_b;
  logic [7:0]  rsp_data_b, i2c_addr_b, i2c_data_b, poll_addr_b, poll_data_b;
  logic        rsp_err_b, busy_b, i2c_start_b, i2c_done_b, poll_valid_b;

  i2c_read_scheduler #(
    .N       (3),
    .TIMEOUT (16'd2000)
`ifdef I2C_SCHED_POLL_EN
    ,
    .POLL_LEN    (4'd2),
    .POLL_PERIOD (20'd5000)
`endif
  ) dut_a (
    .clock (clock), .reset (reset), .req (req_a), .req_addr (req_addr_a),
    .rsp_valid (rsp_valid_a), .rsp_data (rsp_data_a), .rsp_err (rsp_err_a), .busy (busy_a),
    .i2c_addr (i2c_addr_a), .i2c_start (i2c_start_a), .i2c_data (i2c_data_a), .i2c_done (i2c_done_a),
    .poll_valid (poll_valid_a), .poll_addr (poll_addr_a), .poll_data (poll_data_a)
  );

  i2c_read_scheduler #(
    .N       (1),
    .TIMEOUT (16'd50)
  ) dut_b (
    .clock (clock), .reset (reset), .req (req_b), .req_addr (req_addr_b),
    .rsp_valid (rsp_valid_b), .rsp_data (rsp_data_b), .rsp_err (rsp_err_b), .busy (busy_b),
    .i2c_addr (i2c_addr_b), .i2c_start (i2c_start_b), .i2c_data (i2c_data_b), .i2c_done (i2c_done_b),
    .poll_valid (poll_valid_b), .poll_addr (poll_addr_b), .poll_data (poll_data_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] valid;
    logic [7:0] data;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       qa[$];
  exp_t       qb[$];
  logic [7:0] qaddr[$];
  exp_t       ea, eb;

  // Engine models: done arrives lat cycles after the start cycle; reset aborts a pending read.
  int lat_a = 5, lat_b = 5;
  bit mute_b = 1'b0;
  bit abort_a, abort_b;

  initial begin
    i2c_done_a = 1'b0;
    i2c_data_a = 8'h00;
    forever begin
      @(negedge clock);
      i2c_done_a = 1'b0;
      if (i2c_start_a && !reset) begin
        abort_a = 1'b0;
        for (int k = 0; k < lat_a && !abort_a; k++) begin
          @(negedge clock);
          if (reset) abort_a = 1'b1;
        end
        if (!abort_a) begin
          i2c_data_a = i2c_addr_a ^ 8'h1D;
          i2c_done_a = 1'b1;
        end
      end
    end
  end

  initial begin
    i2c_done_b = 1'b0;
    i2c_data_b = 8'h00;
    forever begin
      @(negedge clock);
      i2c_done_b = 1'b0;
      if (i2c_start_b && !reset && !mute_b) begin
        abort_b = 1'b0;
        for (int k = 0; k < lat_b && !abort_b; k++) begin
          @(negedge clock);
          if (reset) abort_b = 1'b1;
        end
        if (!abort_b) begin
          i2c_data_b = i2c_addr_b ^ 8'h1D;
          i2c_done_b = 1'b1;
        end
      end
    end
  end

  int start_cyc_a = 0, starts_a = 0, start_cyc_b = 0, polls_a = 0;
  int poll_cyc[$];
  bit poll_phase = 1'b0;

  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (i2c_start_a) begin
          starts_a++;
          start_cyc_a = cyc;
          if (!poll_phase) begin
            if (qaddr.size() == 0) check("start_unexpected_a", i2c_start_a, 0);
            else check("i2c_addr_a", i2c_addr_a, qaddr.pop_front());
          end
        end
        if (rsp_valid_a != 3'b000) begin
          if (qa.size() == 0) check("rsp_unexpected_a", rsp_valid_a, 0);
          else begin
            ea = qa.pop_front();
            check("rsp_valid_a", rsp_valid_a, ea.valid);
            check("rsp_data_a", rsp_data_a, ea.data);
            check("rsp_err_a", rsp_err_a, ea.err);
            check("rsp_lat_a", cyc - start_cyc_a, ea.lat);
          end
        end
        if (poll_valid_a || poll_addr_a != 8'h00 || poll_data_a != 8'h00) begin
          polls_a++;
          poll_cyc.push_back(cyc);
`ifdef I2C_SCHED_POLL_EN
          check("poll_addr", poll_addr_a, ((polls_a - 1) % 2 == 0) ? 8'h3B : 8'h3C);
          check("poll_data", poll_data_a, poll_addr_a ^ 8'h1D);
`endif
        end
        if (i2c_start_b) start_cyc_b = cyc;
        if (rsp_valid_b) begin
          if (qb.size() == 0) check("rsp_unexpected_b", rsp_valid_b, 0);
          else begin
            eb = qb.pop_front();
            check("rsp_valid_b", rsp_valid_b, eb.valid);
            check("rsp_data_b", rsp_data_b, eb.data);
            check("rsp_err_b", rsp_err_b, eb.err);
            check("rsp_lat_b", cyc - start_cyc_b, eb.lat);
          end
        end
      end
    end
  end

  task automatic wait_rsp_a(input int n, input int budget);
    int got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge clock);
      if (rsp_valid_a != 3'b000) got++;
    end
    check("wait_rsp_a", got, n);
  endtask

  task automatic wait_rsp_b(input int n, input int budget);
    int got = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge clock);
      if (rsp_valid_b) got++;
    end
    check("wait_rsp_b", got, n);
  endtask

  task automatic push_a(input logic [7:0] addr, input logic [2:0] valid, input logic [7:0] data,
                        input logic err, input int lat);
    qaddr.push_back(addr);
    qa.push_back('{valid: valid, data: data, err: err, lat: lat});
  endtask

  logic [7:0] fa [3];
  int starts0;
  int seen;

  initial begin
    reset      = 1'b1;
    req_a      = 3'b000;
    req_addr_a = 24'h0;
    req_b      = 1'b0;
    req_addr_b = 8'h00;
    fa[0] = 8'h10; fa[1] = 8'h21; fa[2] = 8'h32;
    repeat (3) @(negedge clock);
    check("rst_rsp_valid", rsp_valid_a, 0);
    check("rst_rsp_data", rsp_data_a, 0);
    check("rst_rsp_err", rsp_err_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_i2c_addr", i2c_addr_a, 0);
    check("rst_i2c_start", i2c_start_a, 0);
    check("rst_poll", {poll_valid_a, poll_addr_a, poll_data_a}, 0);
    reset = 1'b0;
    @(negedge clock);

`ifdef I2C_SCHED_POLL_EN
    poll_phase = 1'b1;
    for (int k = 0; k < 12000 && polls_a < 4; k++) @(negedge clock);
    check("poll_count", polls_a, 4);
    if (poll_cyc.size() >= 3) check("poll_period", poll_cyc[2] - poll_cyc[0], 5000);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    poll_phase = 1'b0;
    @(negedge clock);
`endif

    // Fairness: all three clients held for six transactions.
    req_addr_a = {fa[2], fa[1], fa[0]};
    lat_a = 5;
    for (int t = 0; t < 6; t++) push_a(fa[t % 3], 3'b001 << (t % 3), fa[t % 3] ^ 8'h1D, 1'b0, 6);
    req_a = 3'b111;
    wait_rsp_a(6, 200);
    req_a = 3'b000;
    @(negedge clock);

    // Single request, 400-cycle engine latency.
    starts0 = starts_a;
    req_addr_a[15:8] = 8'h75;
    lat_a = 400;
    push_a(8'h75, 3'b010, 8'h68, 1'b0, 401);
    req_a = 3'b010;
    repeat (100) @(negedge clock);
    check("busy_mid", busy_a, 1);
    wait_rsp_a(1, 600);
    req_a = 3'b000;
    @(negedge clock);
    check("single_start_pulses", starts_a - starts0, 1);
    check("busy_after", busy_a, 0);

    // Reset 100 cycles into WAIT; pointer is 2 beforehand.
    req_addr_a[7:0] = 8'h0A;
    qaddr.push_back(8'h0A);
    req_a = 3'b001;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clock);
      if (i2c_start_a) seen = 1;
    end
    check("reset_test_start", seen, 1);
    repeat (100) @(negedge clock);
    reset = 1'b1;
    req_a = 3'b000;
    #1;
    check("rstw_rsp_valid", rsp_valid_a, 0);
    check("rstw_busy", busy_a, 0);
    check("rstw_i2c_addr", i2c_addr_a, 0);
    check("rstw_rsp_data", rsp_data_a, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    lat_a = 5;
    repeat (2) @(negedge clock);
    req_addr_a = {8'h52, 8'h41, 8'h0A};
    push_a(8'h41, 3'b010, 8'h5C, 1'b0, 6);
    push_a(8'h52, 3'b100, 8'h4F, 1'b0, 6);
    req_a = 3'b110;
    wait_rsp_a(2, 100);
    req_a = 3'b000;

    // Timeout, race and late-done on the TIMEOUT=50 instance.
    mute_b = 1'b1;
    req_addr_b = 8'h20;
    qb.push_back('{valid: 3'b001, data: 8'h00, err: 1'b1, lat: 51});
    req_b = 1'b1;
    wait_rsp_b(1, 100);
    req_b = 1'b0;
    @(negedge clock);
    check("timeout_idle", busy_b, 0);

    mute_b = 1'b0;
    lat_b = 50;
    req_addr_b = 8'h30;
    qb.push_back('{valid: 3'b001, data: 8'h2D, err: 1'b0, lat: 51});
    req_b = 1'b1;
    wait_rsp_b(1, 100);
    req_b = 1'b0;
    @(negedge clock);

    lat_b = 51;
    req_addr_b = 8'h31;
    qb.push_back('{valid: 3'b001, data: 8'h00, err: 1'b1, lat: 51});
    req_b = 1'b1;
    wait_rsp_b(1, 100);
    req_b = 1'b0;
    repeat (5) @(negedge clock);
    check("late_done_idle", busy_b, 0);

    repeat (10) @(negedge clock);
    check("qa_empty", qa.size(), 0);
    check("qb_empty", qb.size(), 0);
    check("qaddr_empty", qaddr.size(), 0);
`ifndef I2C_SCHED_POLL_EN
    check("no_poll_strobes", polls_a, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
